vec_unpacker: RTL
=================

// Module: vec_unpacker
// PURPOSE
//  Consumer end of the vector fifo. Pops WIDTH-bit vector words from a show-ahead fifo and serialises each
//  into NUM_LANES = WIDTH/LANE_W elements on a valid/ready stream towards the SIMD lane dispatch logic.
//  Sustains 1 element/cycle, with no bubble between consecutive words while the fifo is non-empty.
// PARAMETERS
//  WIDTH   248  vector word width; must equal the fifo WIDTH
//  LANE_W  31   element width; WIDTH % LANE_W != 0 -> $error at elaboration
// PORTS
//  i_clk          in   1       clock
//  i_rstn         in   1       reset, asynchronous, active-low
//  i_fifo_data    in   WIDTH   fifo head word, valid combinationally while i_fifo_empty=0
//  i_fifo_empty   in   1       fifo empty flag
//  o_fifo_read    out  1       pop strobe (combinational); fifo advances on the same clock edge
//  o_elem_data    out  LANE_W  current element; lane 0 = word[LANE_W-1:0]
//  o_elem_valid   out  1       element valid
//  i_elem_ready   in   1       downstream accepts; transfer = valid & ready
//  o_elem_last    out  1       current element is lane NUM_LANES-1 of its word
//  i_flush        in   1       drop the held word and return to IDLE
//  o_busy         out  1       word held (state STREAM)
// BEHAVIOUR
//  - Reset: state=IDLE, lane_idx=0, hold register=0. Outputs: o_elem_valid=0, o_elem_last=0, o_busy=0,
//    o_elem_data=0. o_fifo_read=0 while i_rstn=0.
//  - States: IDLE (no word held), STREAM (word held, o_elem_valid=1).
//  - o_fifo_read = ~i_flush & ~i_fifo_empty & (IDLE | (valid & ready & last)).
//  - Pop edge: i_fifo_data captured into the hold register; lane_idx<=0; state<=STREAM.
//  - Latency: first element is valid the cycle after the pop.
//  - Transfer, not last: lane_idx++. Transfer on last lane: reload in the same edge if the fifo is
//    non-empty, else -> IDLE.
//  - No transfer (ready=0): data, lane_idx and last are held stable. Valid is never retracted except by
//    flush or reset.
//  - o_elem_last = (lane_idx == NUM_LANES-1). Width of lane_idx = $clog2(NUM_LANES), min 1.
//  - i_flush has priority over everything:
//    - no pop; state<=IDLE; lane_idx<=0.
//    - a transfer in the same cycle still counts downstream; the rest of the word is discarded.
//  - Fifo empty in IDLE: stay in IDLE, no pop.
//  - Never pop while empty. Never pop while holding a word except on the last-lane transfer.
//  - Reset mid-word: the held word is lost. The fifo resets on the same i_rstn.
// CONFIGURATION
//  VEC_UNPACK_STATS_EN defined:
//    - Adds outputs o_words_popped [31:0] (+1 per o_fifo_read) and o_elems_sent [31:0] (+1 per transfer).
//    - Both counters wrap, reset to 0, and are not cleared by i_flush.
//  Not defined: these ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  - simd_pkg: VEC_WIDTH=248, LANE_W=31, NUM_LANES, lane_idx_t, typedef enum {IDLE, STREAM} unpack_state_t.
//  - Sub-module vec_lane_mux (combinational): WIDTH word + lane_idx -> LANE_W element.
// TESTING (defaults, 8 lanes; bench fifo model is show-ahead)
//  1. Push word W0 with lane k = k+1; ready=1:
//     - pop 1 cycle, then elements 1..8 on 8 consecutive cycles;
//     - last=1 only on 8, then IDLE.
//  2. Push W0,W1 back-to-back; ready=1:
//     - 16 elements on 16 consecutive cycles;
//     - second pop coincides with the transfer of W0 lane 7.
//  3. ready toggles 1,0,1,0: data/last stable through the stalls; 8 elements in 16 cycles; no extra pops.
//  4. Flush after 3 transfers of W0 with W1 queued:
//     - valid drops the next cycle, no pop on the flush cycle;
//     - W1 is popped the following cycle and streams lane 0 first.
//  5. Assert reset mid-word (lane 4): all outputs go to 0 immediately; no pop until the fifo is refilled.
//  6. VEC_UNPACK_STATS_EN: after scenario 2, o_words_popped=2 and o_elems_sent=16.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared SIMD vector types for the vector fifo unpacker.
// Lane geometry defaults and the unpacker state encoding.
package simd_pkg;

  localparam int VEC_WIDTH = 248;
  localparam int LANE_W = 31;
  localparam int NUM_LANES = VEC_WIDTH / LANE_W;
  localparam int LANE_IDX_W =
    (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

  typedef enum logic {
    IDLE,
    STREAM
  } unpack_state_t;

endpackage

// File: rtl/vec_unpacker_if.sv
// Fifo-head and element-stream bundle for vec_unpacker.
// slave = unpacker side, master = fifo/dispatch side.
interface vec_unpacker_if #(
  parameter int WIDTH = 248,
  parameter int LANE_W = 31
);

  logic [WIDTH-1:0]  fifo_data;
  logic              fifo_empty;
  logic              fifo_read;
  logic [LANE_W-1:0] elem_data;
  logic              elem_valid;
  logic              elem_ready;
  logic              elem_last;

  modport slave (
    input  fifo_data,
    input  fifo_empty,
    output fifo_read,
    output elem_data,
    output elem_valid,
    input  elem_ready,
    output elem_last
  );

  modport master (
    output fifo_data,
    output fifo_empty,
    input  fifo_read,
    input  elem_data,
    input  elem_valid,
    output elem_ready,
    input  elem_last
  );

endinterface

// File: rtl/vec_lane_mux.sv
// Combinational lane select: picks element idx_i
// out of a packed vector word, lane 0 in the LSBs.
module vec_lane_mux #(
  parameter int WIDTH = 248,
  parameter int LANE_W = 31,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0]  word_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [LANE_W-1:0] elem_o
);

  localparam int NL = WIDTH / LANE_W;

  logic [LANE_W-1:0] lanes [NL];

  for (genvar k = 0; k < NL; k++) begin : g_lane
    assign lanes[k] = word_i[k*LANE_W +: LANE_W];
  end

  assign elem_o = lanes[idx_i];

endmodule

// File: rtl/vec_unpacker.sv
// Pops vector words from a show-ahead fifo and streams their lanes.
// Optional counters: define VEC_UNPACK_STATS_EN.
module vec_unpacker
  import simd_pkg::*;
#(
  parameter int WIDTH = VEC_WIDTH,
  parameter int LANE_W = simd_pkg::LANE_W
) (
  input  logic  i_clk,
  input  logic  i_rstn,
  vec_unpacker_if.slave bus,
  input  logic  i_flush,
  output logic  o_busy
`ifdef VEC_UNPACK_STATS_EN
  ,
  output logic [31:0] o_words_popped,
  output logic [31:0] o_elems_sent
`endif
);

  localparam int NL = WIDTH / LANE_W;
  localparam int IDX_W = (NL > 1) ? $clog2(NL) : 1;

  if (WIDTH % LANE_W != 0) begin : g_bad_geom
    $error("vec_unpacker: WIDTH must be a multiple of LANE_W");
  end

  unpack_state_t     state_q;
  logic [IDX_W-1:0]  lane_q;
  logic [WIDTH-1:0]  hold_q;

  logic valid;
  logic last;
  logic xfer;
  logic pop;

  assign valid = (state_q == STREAM);
  assign last = (lane_q == IDX_W'(NL - 1));
  assign xfer = valid & bus.elem_ready;
  // Reload on the last-lane transfer keeps the stream bubble-free.
  assign pop = i_rstn & ~i_flush & ~bus.fifo_empty &
               (~valid | (xfer & last));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      lane_q <= '0;
      hold_q <= '0;
    end else if (i_flush) begin
      state_q <= IDLE;
      lane_q <= '0;
    end else if (pop) begin
      state_q <= STREAM;
      lane_q <= '0;
      hold_q <= bus.fifo_data;
    end else if (xfer) begin
      if (last) begin
        state_q <= IDLE;
        lane_q <= '0;
      end else begin
        lane_q <= lane_q + IDX_W'(1);
      end
    end
  end

  vec_lane_mux #(
    .WIDTH (WIDTH),
    .LANE_W(LANE_W),
    .IDX_W (IDX_W)
  ) u_mux (
    .word_i(hold_q),
    .idx_i (lane_q),
    .elem_o(bus.elem_data)
  );

  assign bus.fifo_read = pop;
  assign bus.elem_valid = valid;
  assign bus.elem_last = valid & last;
  assign o_busy = valid;

`ifdef VEC_UNPACK_STATS_EN
  logic [31:0] words_q;
  logic [31:0] elems_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      words_q <= '0;
      elems_q <= '0;
    end else begin
      if (pop) words_q <= words_q + 32'd1;
      if (xfer) elems_q <= elems_q + 32'd1;
    end
  end

  assign o_words_popped = words_q;
  assign o_elems_sent = elems_q;
`endif

endmodule
